// File: rtl/dma_burst_arbiter_if.sv
// rtl/dma_burst_arbiter_if.sv - requester-side and downstream burst handshake bundle
interface dma_burst_arbiter_if #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 64,
    parameter int LenWidth  = 8,
    parameter int IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
);
    logic [NumReq-1:0]                req_valid_i;
    logic [NumReq-1:0][LenWidth-1:0]  req_len_i;
    logic [NumReq-1:0]                req_ready_o;
    logic [NumReq-1:0]                beat_valid_i;
    logic [NumReq-1:0][DataWidth-1:0] beat_data_i;
    logic [NumReq-1:0]                beat_ready_o;
    logic                             m_req_valid_o;
    logic [LenWidth-1:0]              m_req_len_o;
    logic [IdWidth-1:0]               m_req_id_o;
    logic                             m_req_ready_i;
    logic                             m_beat_valid_o;
    logic [DataWidth-1:0]             m_beat_data_o;
    logic                             m_beat_last_o;
    logic                             m_beat_ready_i;

    modport slave (
        input  req_valid_i, req_len_i, beat_valid_i, beat_data_i,
        input  m_req_ready_i, m_beat_ready_i,
        output req_ready_o, beat_ready_o,
        output m_req_valid_o, m_req_len_o, m_req_id_o,
        output m_beat_valid_o, m_beat_data_o, m_beat_last_o
    );

    modport master (
        output req_valid_i, req_len_i, beat_valid_i, beat_data_i,
        output m_req_ready_i, m_beat_ready_i,
        input  req_ready_o, beat_ready_o,
        input  m_req_valid_o, m_req_len_o, m_req_id_o,
        input  m_beat_valid_o, m_beat_data_o, m_beat_last_o
    );
endinterface

// File: rtl/dma_burst_arbiter.sv
// rtl/dma_burst_arbiter.sv - round-robin burst arbiter sharing one DRAM burst port
module dma_burst_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 64,
    parameter int LenWidth  = 8,
    parameter int IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dma_burst_arbiter_if.slave    bus,
    output logic [NumReq-1:0]     grant_o,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, REQ, DATA} state_e;

    state_e              state_q, state_d;
    logic [IdWidth-1:0]  gnt_q, gnt_d;
    logic [IdWidth-1:0]  last_q, last_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] cnt_q, cnt_d;
    logic [IdWidth-1:0]  winner;

    logic [NumReq-1:0]    req_ready;
    logic [NumReq-1:0]    beat_ready;
    logic [NumReq-1:0]    grant;
    logic                 m_req_valid;
    logic [LenWidth-1:0]  m_req_len;
    logic [IdWidth-1:0]   m_req_id;
    logic                 m_beat_valid;
    logic [DataWidth-1:0] m_beat_data;
    logic                 m_beat_last;

    // Scan from the farthest position down so the nearest requester after last_q wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = last_q;
        for (int i = NumReq; i >= 1; i--) begin
            idx = (int'(last_q) + i) % NumReq;
            if (bus.req_valid_i[idx]) begin
                winner = idx[IdWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IdWidth'(NumReq - 1);
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        beat_ready   = '0;
        grant        = '0;
        m_req_valid  = 1'b0;
        m_req_len    = '0;
        m_req_id     = '0;
        m_beat_valid = 1'b0;
        m_beat_data  = '0;
        m_beat_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid_i) begin
                    gnt_d   = winner;
                    last_d  = winner;
                    len_d   = bus.req_len_i[winner];
                    cnt_d   = bus.req_len_i[winner];
                    state_d = REQ;
                end
            end
            REQ: begin
                grant[gnt_q]     = 1'b1;
                m_req_valid      = 1'b1;
                m_req_len        = len_q;
                m_req_id         = gnt_q;
                req_ready[gnt_q] = bus.m_req_ready_i;
                if (bus.m_req_ready_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                grant[gnt_q]      = 1'b1;
                m_beat_valid      = bus.beat_valid_i[gnt_q];
                m_beat_data       = bus.beat_data_i[gnt_q];
                beat_ready[gnt_q] = bus.m_beat_ready_i;
                m_beat_last       = m_beat_valid && (cnt_q == '0);
                // Leaving at zero means cnt_q never wraps, even for the longest burst.
                if (m_beat_valid && bus.m_beat_ready_i) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready_o    = req_ready;
    assign bus.beat_ready_o   = beat_ready;
    assign bus.m_req_valid_o  = m_req_valid;
    assign bus.m_req_len_o    = m_req_len;
    assign bus.m_req_id_o     = m_req_id;
    assign bus.m_beat_valid_o = m_beat_valid;
    assign bus.m_beat_data_o  = m_beat_data;
    assign bus.m_beat_last_o  = m_beat_last;
    assign grant_o            = grant;
    assign busy_o             = (state_q != IDLE);
endmodule

// File: tb/tb_dma_burst_arbiter.sv
// tb/tb_dma_burst_arbiter.sv - directed scoreboard bench for dma_burst_arbiter
module tb_dma_burst_arbiter;
    localparam int NumReq    = 4;
    localparam int DataWidth = 64;
    localparam int LenWidth  = 8;
    localparam int IdWidth   = 2;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NumReq-1:0] grant_o;
    logic              busy_o;

    dma_burst_arbiter_if #(.NumReq(NumReq), .DataWidth(DataWidth),
                           .LenWidth(LenWidth), .IdWidth(IdWidth)) bus ();

    dma_burst_arbiter #(.NumReq(NumReq), .DataWidth(DataWidth),
                        .LenWidth(LenWidth), .IdWidth(IdWidth)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .bus     (bus.slave),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int beat_cnt = 0;
    int last_cnt = 0;
    logic [NumReq-1:0] own_mask = '0;
    beat_t beat_q[$];
    logic [IdWidth+LenWidth-1:0] req_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] pat(input int id, input int b);
        return {8'(id), 24'hC0FFEE, 32'(b)};
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("nonowner_req_ready", 64'(bus.req_ready_o & ~own_mask), 64'd0);
            check("nonowner_beat_ready", 64'(bus.beat_ready_o & ~own_mask), 64'd0);
            check("grant_onehot0", 64'($onehot0(grant_o)), 64'd1);
            if (bus.m_req_valid_o && bus.m_req_ready_i) begin
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL req_unexpected observed id=%0d len=%0d expected none",
                           bus.m_req_id_o, bus.m_req_len_o);
                end else begin
                    check("req_id_len", 64'({bus.m_req_id_o, bus.m_req_len_o}),
                          64'(req_q.pop_front()));
                end
            end
            if (bus.m_beat_valid_o) begin
                if (beat_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL beat_unexpected observed=%0h expected none", bus.m_beat_data_o);
                end else begin
                    check("beat_data", bus.m_beat_data_o, beat_q[0].data);
                    check("beat_last", 64'(bus.m_beat_last_o), 64'(beat_q[0].last));
                    if (bus.m_beat_ready_i) begin
                        check("beat_ready_owner", 64'(bus.beat_ready_o), 64'(own_mask));
                        void'(beat_q.pop_front());
                        beat_cnt++;
                        if (bus.m_beat_last_o) last_cnt++;
                    end
                end
            end
        end
    end

    task automatic serve(input int id, input int len, input int stall, input bit toggle,
                         input bit keep, input int stop_after);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (bus.m_req_valid_o) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $error("FAIL req_timeout observed no m_req_valid_o expected grant to %0d", id);
            return;
        end
        check("grant", 64'(grant_o), 64'd1 << id);
        check("busy_req", 64'(busy_o), 64'd1);
        own_mask = NumReq'(1 << id);
        req_q.push_back({IdWidth'(id), LenWidth'(len)});
        repeat (stall) begin
            tick();
            check("req_held", 64'(bus.m_req_valid_o), 64'd1);
            check("req_ready_stall", 64'(bus.req_ready_o), 64'd0);
        end
        bus.m_req_ready_i = 1'b1;
        #1;
        check("req_ready_owner", 64'(bus.req_ready_o), 64'(own_mask));
        tick();
        bus.m_req_ready_i = 1'b0;
        if (!keep) bus.req_valid_i[id] = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (b == stop_after) break;
            bus.beat_valid_i[id] = 1'b1;
            bus.beat_data_i[id]  = pat(id, b);
            beat_q.push_back({pat(id, b), (b == len)});
            if (toggle) begin
                bus.m_beat_ready_i = 1'b0;
                tick();
            end
            bus.m_beat_ready_i = 1'b1;
            tick();
        end
        bus.m_beat_ready_i   = 1'b0;
        bus.beat_valid_i[id] = 1'b0;
        if (stop_after < 0) begin
            check("busy_after_last", 64'(busy_o), 64'd0);
            own_mask = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_grant"}, 64'(grant_o), 64'd0);
        check({tag, "_m_req_valid"}, 64'(bus.m_req_valid_o), 64'd0);
        check({tag, "_m_req_len_id"}, 64'({bus.m_req_id_o, bus.m_req_len_o}), 64'd0);
        check({tag, "_m_beat"}, 64'({bus.m_beat_valid_o, bus.m_beat_last_o}), 64'd0);
        check({tag, "_readies"}, 64'({bus.req_ready_o, bus.beat_ready_o}), 64'd0);
    endtask

    initial begin
        int b0;
        int l0;
        bus.req_valid_i    = '0;
        bus.req_len_i      = '0;
        bus.beat_valid_i   = '0;
        bus.beat_data_i    = '0;
        bus.m_req_ready_i  = 1'b0;
        bus.m_beat_ready_i = 1'b0;

        rst_i = 1'b1;
        repeat (2) tick();
        check_all_zero("reset");
        rst_i = 1'b0;

        bus.req_len_i[1]   = 8'd3;
        bus.req_valid_i[1] = 1'b1;
        #1;
        check("idle_no_req", 64'(bus.m_req_valid_o), 64'd0);
        tick();
        check("arb_latency", 64'(bus.m_req_valid_o), 64'd1);
        check("single_id", 64'(bus.m_req_id_o), 64'd1);
        check("single_len", 64'(bus.m_req_len_o), 64'd3);
        serve(1, 3, 0, 1'b0, 1'b0, -1);

        bus.req_len_i[2]   = 8'd1;
        bus.req_valid_i[2] = 1'b1;
        serve(2, 1, 0, 1'b0, 1'b0, -1);
        bus.req_len_i[1]   = 8'd2;
        bus.req_len_i[3]   = 8'd0;
        bus.req_valid_i[1] = 1'b1;
        bus.req_valid_i[3] = 1'b1;
        serve(3, 0, 0, 1'b0, 1'b0, -1);
        serve(1, 2, 0, 1'b0, 1'b0, -1);

        for (int r = 0; r < NumReq; r++) bus.beat_data_i[r] = 64'hBAD0_0000 + 64'(r);
        bus.beat_valid_i   = '1;
        bus.req_len_i[0]   = 8'd7;
        bus.req_valid_i[0] = 1'b1;
        b0 = beat_cnt;
        serve(0, 7, 5, 1'b1, 1'b0, -1);
        check("bp_beats", 64'(beat_cnt - b0), 64'd8);
        bus.beat_valid_i = '0;

        bus.req_len_i[2]   = 8'd0;
        bus.req_valid_i[2] = 1'b1;
        b0 = beat_cnt;
        l0 = last_cnt;
        serve(2, 0, 0, 1'b0, 1'b0, -1);
        check("len0_beats", 64'(beat_cnt - b0), 64'd1);
        check("len0_lasts", 64'(last_cnt - l0), 64'd1);
        bus.req_len_i[2]   = 8'd255;
        bus.req_valid_i[2] = 1'b1;
        b0 = beat_cnt;
        l0 = last_cnt;
        serve(2, 255, 0, 1'b0, 1'b0, -1);
        check("len255_beats", 64'(beat_cnt - b0), 64'd256);
        check("len255_lasts", 64'(last_cnt - l0), 64'd1);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        bus.req_len_i   = '0;
        bus.req_valid_i = '1;
        serve(0, 0, 0, 1'b0, 1'b1, -1);
        serve(1, 0, 0, 1'b0, 1'b1, -1);
        serve(2, 0, 0, 1'b0, 1'b1, -1);
        serve(3, 0, 0, 1'b0, 1'b1, -1);
        serve(0, 0, 0, 1'b0, 1'b1, -1);
        bus.req_valid_i = '0;

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("reset_from_req_busy", 64'(busy_o), 64'd0);
        bus.req_len_i[0]   = 8'd5;
        bus.req_valid_i[0] = 1'b1;
        serve(0, 5, 0, 1'b0, 1'b0, 2);
        rst_i = 1'b1;
        tick();
        rst_i    = 1'b0;
        own_mask = '0;
        check_all_zero("midburst_reset");
        bus.beat_valid_i[0] = 1'b1;
        bus.m_beat_ready_i  = 1'b1;
        #1;
        check("abandoned_beat_ready", 64'(bus.beat_ready_o), 64'd0);
        check("abandoned_beat_valid", 64'(bus.m_beat_valid_o), 64'd0);
        tick();
        bus.beat_valid_i[0] = 1'b0;
        bus.m_beat_ready_i  = 1'b0;
        bus.req_len_i[3]    = 8'd9;
        bus.req_valid_i[3]  = 1'b1;
        serve(3, 9, 0, 1'b0, 1'b0, -1);

        tick();
        check("beat_q_empty", 64'(beat_q.size()), 64'd0);
        check("req_q_empty", 64'(req_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dma_burst_arbiter.md
# dma_burst_arbiter

Round-robin arbiter that shares one DRAM-facing burst port between the `NrDmaMasters` (4) iDMA engines configured through DMA_CFG_0..3. A grant is held for one complete burst: one request handshake, then `len+1` data beats. The grant is released only after the last beat handshake. The block sits between the DMA engine write paths and the DMA crossbar input.

## Interface
- `NumReq`, default 4: number of requesters; equals `ariane_soc::NrDmaMasters`.
- `DataWidth`, default 64: beat data width.
- `LenWidth`, default 8: burst length field width. Value is beats minus 1, as in AXI.
- `IdWidth`, default `$clog2(NumReq)`: width of the granted-requester index.

- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in `NumReq`: burst request per requester. Must be held until `req_ready_o`.
- `req_len_i` in `NumReq`x`LenWidth`: burst length minus 1 per requester. Stable while `req_valid_i` is high.
- `req_ready_o` out `NumReq`: request accepted.
- `beat_valid_i` in `NumReq`: data beat valid per requester.
- `beat_data_i` in `NumReq`x`DataWidth`: beat data.
- `beat_ready_o` out `NumReq`: beat accepted.
- `m_req_valid_o` out 1: request to downstream.
- `m_req_len_o` out `LenWidth`: latched length of the granted burst.
- `m_req_id_o` out `IdWidth`: index of the granted requester.
- `m_req_ready_i` in 1: downstream accepts the request.
- `m_beat_valid_o` out 1: beat to downstream.
- `m_beat_data_o` out `DataWidth`: beat data.
- `m_beat_last_o` out 1: final beat of the burst.
- `m_beat_ready_i` in 1: downstream accepts the beat.
- `grant_o` out `NumReq`: one-hot current owner; zero when idle.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- **FSM states.** IDLE, REQ, DATA.
- **IDLE.**
  - If any `req_valid_i` is high, pick a winner by round-robin.
  - Latch `gnt_q`, `len_q = req_len_i[winner]` and `cnt_q = req_len_i[winner]`.
  - Update the pointer `last_q = winner` and go to REQ.
- **Round-robin priority.** Order is `last_q+1, last_q+2, …` modulo `NumReq`. The last winner has lowest priority.
- **REQ.**
  - `m_req_valid_o = 1`, `m_req_len_o = len_q`, `m_req_id_o = gnt_q`.
  - `req_ready_o[gnt_q] = m_req_ready_i`, combinational.
  - On `m_req_valid_o & m_req_ready_i`, go to DATA.
- **DATA.**
  - Combinational pass-through from the owner: `m_beat_valid_o = beat_valid_i[gnt_q]`, `m_beat_data_o = beat_data_i[gnt_q]`, `beat_ready_o[gnt_q] = m_beat_ready_i`.
  - `m_beat_last_o = m_beat_valid_o & (cnt_q == 0)`.
  - On each beat handshake: if `cnt_q == 0`, go to IDLE; otherwise decrement `cnt_q`.
- **Non-owner outputs.** Every `req_ready_o` and `beat_ready_o` bit of a non-owner is 0 in all states. All outputs are 0 in IDLE.
- **Input isolation.** Beats offered by a requester before its grant, or outside DATA, are not accepted. Requests arriving while not IDLE wait; no request is dropped.
- **Length boundaries.** `len = 0` gives a single beat with `m_beat_last_o` on it. `len = 2^LenWidth - 1` gives 256 beats for the default width; `cnt_q` never wraps because the exit happens at 0.
- **Simultaneous events.** A request rising in the same cycle as the final beat handshake is seen in the following IDLE cycle.

## Timing
- **Reset values.** All outputs 0; state IDLE; `cnt_q = 0`; `len_q = 0`; `gnt_q = 0`; `last_q = NumReq-1`, so requester 0 wins first after reset.
- **Reset mid-burst.** FSM returns to IDLE the next edge. The in-flight burst is abandoned and no further ready is given to its owner.
- **Arbitration latency.** `req_valid_i` high in IDLE at cycle N gives `m_req_valid_o` high at N+1.
- **Minimum burst occupancy.** `len+3` cycles: 1 IDLE + ≥1 REQ + `len+1` DATA beats. There is one bubble (IDLE) between consecutive bursts.
- **Data path.** Beat data, valid and ready are combinational; no added data latency.
- **Registers.** `last_q`, `gnt_q`, `len_q` and `cnt_q` are updated only at the points listed in Operation.

## Test plan
- **Single burst.**
  - Stimulus: requester 1, `len=3`, downstream always ready.
  - Response: `m_req_valid_o` one cycle after the request with `m_req_id_o=1`, `m_req_len_o=3`. Then 4 beats forwarded in order, `m_beat_last_o` only on the 4th. `busy_o` falls one cycle after the last beat.
- **Fairness.**
  - Stimulus: all 4 requesters request `len=0` continuously after reset.
  - Response: grant order 0,1,2,3,0; each grant is one-hot on `grant_o`.
- **Rotation.**
  - Stimulus: after requester 2 is served, requesters 1 and 3 request together.
  - Response: 3 is granted before 1.
- **Backpressure.**
  - Stimulus: `m_req_ready_i` low for 5 cycles, then `m_beat_ready_i` toggling every cycle during a `len=7` burst.
  - Response: 8 beats transferred with no loss or duplication. `cnt_q` decrements only on handshakes. Non-owner `beat_ready_o` stays 0 throughout.
- **Reset mid-burst.**
  - Stimulus: `rst_i` high for one cycle after beat 2 of a `len=5` burst from requester 0.
  - Response: all outputs 0 the next cycle. A fresh request from requester 3 is then granted with `m_req_len_o` equal to its own length.
- **Length extremes.**
  - Stimulus: `len=0` and `len=255` bursts.
  - Response: 1 and 256 beats respectively, `m_beat_last_o` exactly once each.
